// File: rtl/vproc_mem_model_pkg.sv
// Shared types and constants for the vproc multi-port memory model.
// The LFSR step lives here so every port advances the same polynomial.
package vproc_mem_model_pkg;

  typedef enum logic {
    STALL_NONE,
    STALL_LFSR
  } mem_stall_e;

  // Fibonacci taps 16,14,13,11 (maximal length)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vproc_mem_model_if.sv
// Request/response bundle between requesters (master) and the memory model (slave).
// A request is taken on a rising edge where req & gnt; rvalid qualifies err and rdata.
interface vproc_mem_model_if #(
  parameter int N_PORTS = 2,
  parameter int MEM_W   = 32
);

  logic [N_PORTS-1:0]                req;
  logic [N_PORTS-1:0][31:0]          addr;
  logic [N_PORTS-1:0]                we;
  logic [N_PORTS-1:0][MEM_W/8-1:0]   be;
  logic [N_PORTS-1:0][MEM_W-1:0]     wdata;
  logic [N_PORTS-1:0]                gnt;
  logic [N_PORTS-1:0]                rvalid;
  logic [N_PORTS-1:0]                err;
  logic [N_PORTS-1:0][MEM_W-1:0]     rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, err, rdata
  );

endinterface

// File: rtl/vproc_mem_lat_pipe.sv
// Per-port response delay line: stage 0 is loaded at the accept edge, the last stage drives the port.
// Latency LATENCY cycles; no backpressure, synchronous clear drops everything in flight.
module vproc_mem_lat_pipe #(
  parameter int  LATENCY = 1,
  parameter type rsp_t   = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  rsp_t rsp_i,
  output rsp_t rsp_o
);

  rsp_t stage_d [LATENCY];
  rsp_t stage_q [LATENCY];

  always_comb begin
    stage_d[0] = rsp_i;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign rsp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/vproc_mem_model.sv
// Multi-port simulation memory with per-port grant stalls, fixed response latency and a sticky halt flag.
// Response LATENCY cycles after accept; gnt comes from a per-port LFSR (or is always high outside reset).
module vproc_mem_model
  import vproc_mem_model_pkg::*;
#(
  parameter int          N_PORTS    = 2,
  parameter int          MEM_W      = 32,
  parameter int          MEM_SZ     = 262144,
  parameter int          LATENCY    = 1,
  parameter mem_stall_e  STALL_MODE = STALL_NONE,
  parameter logic [31:0] STALL_SEED = 32'hACE1,
  parameter logic [31:0] HALT_ADDR  = 32'h0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vproc_mem_model_if.slave mem_if,
  output logic             halt_o
);

  localparam int BE_W     = MEM_W / 8;
  localparam int ADDR_LSB = $clog2(BE_W);
  localparam int ADDR_MSB = $clog2(MEM_SZ);
  localparam int IDX_W    = ADDR_MSB - ADDR_LSB;
  localparam int N_WORDS  = MEM_SZ / BE_W;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [MEM_W-1:0] rdata;
  } mem_rsp_t;

  logic [MEM_W-1:0] mem [N_WORDS];

  logic [N_PORTS-1:0]               gnt;
  logic [N_PORTS-1:0]               acc;
  logic [N_PORTS-1:0]               oor;
  logic [N_PORTS-1:0]               wr_en;
  logic [N_PORTS-1:0][IDX_W-1:0]    idx;
  logic [N_PORTS-1:0][ADDR_LSB-1:0] unused_addr_lsb;
  logic [N_PORTS-1:0][MEM_W-1:0]    rd_word;
  logic [N_PORTS-1:0][MEM_W-1:0]    wr_word;
  logic [N_PORTS-1:0][15:0]         lfsr_d, lfsr_q;
  logic                             halt_d, halt_q;
  mem_rsp_t                         rsp_in  [N_PORTS];
  mem_rsp_t                         rsp_out [N_PORTS];

  function automatic logic all_x(input logic [MEM_W-1:0] w);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MEM_W; i++) begin
      r &= $isunknown(w[i]);
    end
    return r;
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    gnt    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      lfsr_d[p] = lfsr_next(lfsr_q[p]);
      gnt[p]    = ~rst_i & ((STALL_MODE == STALL_NONE) ? 1'b1 : ~(lfsr_q[p][1] & lfsr_q[p][0]));
    end
  end

  assign mem_if.gnt = gnt;

  always_comb begin
    acc             = mem_if.req & gnt;
    oor             = '0;
    idx             = '0;
    wr_en           = '0;
    unused_addr_lsb = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      oor[p]             = |mem_if.addr[p][31:ADDR_MSB];
      idx[p]             = mem_if.addr[p][ADDR_MSB-1:ADDR_LSB];
      wr_en[p]           = acc[p] & mem_if.we[p] & ~oor[p];
      unused_addr_lsb[p] = mem_if.addr[p][ADDR_LSB-1:0];
    end
    halt_d = halt_q | (acc[0] & (mem_if.addr[0] == HALT_ADDR));
  end

  // Never-written (all-X) words behave as zero; writes to a word from several
  // ports are merged per byte with the lowest-indexed port applied last.
  always_comb begin
    rd_word = '0;
    wr_word = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      rd_word[p] = all_x(mem[idx[p]]) ? '0 : mem[idx[p]];
      wr_word[p] = rd_word[p];
      for (int q = N_PORTS - 1; q >= 0; q--) begin
        if (wr_en[q] && (idx[q] == idx[p])) begin
          for (int b = 0; b < BE_W; b++) begin
            if (mem_if.be[q][b]) begin
              wr_word[p][8*b +: 8] = mem_if.wdata[q][8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      rsp_in[p].valid = acc[p];
      rsp_in[p].err   = acc[p] & oor[p];
      rsp_in[p].rdata = (acc[p] & ~mem_if.we[p] & ~oor[p]) ? rd_word[p] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (wr_en[p]) begin
        mem[idx[p]] <= wr_word[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_q <= 1'b0;
      for (int p = 0; p < N_PORTS; p++) begin
        lfsr_q[p] <= STALL_SEED[15:0] ^ 16'(p);
      end
    end else begin
      halt_q <= halt_d;
      lfsr_q <= lfsr_d;
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    vproc_mem_lat_pipe #(
      .LATENCY (LATENCY),
      .rsp_t   (mem_rsp_t)
    ) u_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .rsp_i (rsp_in[p]),
      .rsp_o (rsp_out[p])
    );
  end

  always_comb begin
    mem_if.rvalid = '0;
    mem_if.err    = '0;
    mem_if.rdata  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      mem_if.rvalid[p] = rsp_out[p].valid;
      mem_if.err[p]    = rsp_out[p].err;
      mem_if.rdata[p]  = rsp_out[p].rdata;
    end
  end

  assign halt_o = halt_q;

endmodule

// File: tb/tb_vproc_mem_model.sv
// Directed bench for vproc_mem_model: basic, byte-enable, range, collision, latency,
// LFSR stall, mid-burst reset and halt behaviour across three instances.
module tb_vproc_mem_model;
  import vproc_mem_model_pkg::*;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  logic halt0, halt1, halt2;

  int n_checks = 0;
  int n_errors = 0;

  int   low0, low1, acc0, acc1, rsp0, rsp1, cnt;
  logic granted;
  logic exp_v;
  logic [31:0] exp_d;

  always #5 clk = ~clk;

  vproc_mem_model_if #(.N_PORTS(2), .MEM_W(32)) if0 ();
  vproc_mem_model_if #(.N_PORTS(1), .MEM_W(32)) if1 ();
  vproc_mem_model_if #(.N_PORTS(2), .MEM_W(32)) if2 ();

  vproc_mem_model #(
    .N_PORTS(2), .MEM_W(32), .MEM_SZ(262144), .LATENCY(1),
    .STALL_MODE(STALL_NONE), .STALL_SEED(32'hACE1), .HALT_ADDR(32'h0)
  ) dut0 (.clk_i(clk), .rst_i(rst), .mem_if(if0), .halt_o(halt0));

  vproc_mem_model #(
    .N_PORTS(1), .MEM_W(32), .MEM_SZ(4096), .LATENCY(3),
    .STALL_MODE(STALL_NONE), .STALL_SEED(32'hACE1), .HALT_ADDR(32'h0)
  ) dut1 (.clk_i(clk), .rst_i(rst), .mem_if(if1), .halt_o(halt1));

  vproc_mem_model #(
    .N_PORTS(2), .MEM_W(32), .MEM_SZ(4096), .LATENCY(2),
    .STALL_MODE(STALL_LFSR), .STALL_SEED(32'hACE1), .HALT_ADDR(32'h0)
  ) dut2 (.clk_i(clk), .rst_i(rst2), .mem_if(if2), .halt_o(halt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(input int p, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd);
    if0.req[p]   = 1'b1;
    if0.we[p]    = we;
    if0.addr[p]  = addr;
    if0.be[p]    = be;
    if0.wdata[p] = wd;
    tick();
    if0.req[p]   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    if0.req = '0; if0.we = '0; if0.addr = '0; if0.be = '0; if0.wdata = '0;
    if1.req = '0; if1.we = '0; if1.addr = '0; if1.be = '0; if1.wdata = '0;
    if2.req = '0; if2.we = '0; if2.addr = '0; if2.be = '0; if2.wdata = '0;

    // reset state
    repeat (3) tick();
    chk("rst_gnt0",    32'(if0.gnt),       32'h0);
    chk("rst_gnt2",    32'(if2.gnt),       32'h0);
    chk("rst_rvalid0", 32'(if0.rvalid),    32'h0);
    chk("rst_err0",    32'(if0.err),       32'h0);
    chk("rst_rdata0",  if0.rdata[0],       32'h0);
    chk("rst_halt0",   32'(halt0),         32'h0);
    chk("rst_rvalid2", 32'(if2.rvalid),    32'h0);
    rst  = 1'b0;
    rst2 = 1'b0;
    #1;
    chk("gnt0_after_rst", 32'(if0.gnt), 32'h3);

    // basic write then read
    op0(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    chk("wr_rvalid", 32'(if0.rvalid[0]), 32'h1);
    chk("wr_err",    32'(if0.err[0]),    32'h0);
    chk("wr_rdata",  if0.rdata[0],       32'h0);
    tick();
    chk("wr_rvalid_one_cycle", 32'(if0.rvalid[0]), 32'h0);
    op0(0, 1'b0, 32'h100, 4'h0, 32'h0);
    chk("rd_rvalid", 32'(if0.rvalid[0]), 32'h1);
    chk("rd_data",   if0.rdata[0],       32'hDEADBEEF);

    // byte enables
    op0(0, 1'b1, 32'h20, 4'hF,    32'h11223344);
    op0(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    op0(0, 1'b0, 32'h20, 4'h0,    32'h0);
    chk("be_merge", if0.rdata[0], 32'h11BB33DD);

    // range check: out-of-range read/write error; write must not alias into word 0
    op0(0, 1'b0, 32'h00040000, 4'h0, 32'h0);
    chk("oor_rd_err",   32'(if0.err[0]), 32'h1);
    chk("oor_rd_rdata", if0.rdata[0],    32'h0);
    op0(0, 1'b1, 32'h00040000, 4'hF, 32'hCAFEF00D);
    chk("oor_wr_err",   32'(if0.err[0]), 32'h1);
    op0(1, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("oor_wr_suppressed", if0.rdata[1], 32'h0);
    chk("inrange_err",       32'(if0.err[1]), 32'h0);

    // same-word write collision: port 0 wins
    if0.req = 2'b11; if0.we = 2'b11;
    if0.addr[0] = 32'h40; if0.addr[1] = 32'h40;
    if0.be[0] = 4'hF; if0.be[1] = 4'hF;
    if0.wdata[0] = 32'h1; if0.wdata[1] = 32'h2;
    tick();
    if0.req = 2'b00;
    chk("coll_rvalid", 32'(if0.rvalid), 32'h3);
    op0(0, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("coll_word", if0.rdata[0], 32'h1);

    // per-byte collision: port 0 owns only the low half
    if0.req = 2'b11; if0.we = 2'b11;
    if0.addr[0] = 32'h44; if0.addr[1] = 32'h44;
    if0.be[0] = 4'b0011; if0.be[1] = 4'hF;
    if0.wdata[0] = 32'h0000AAAA; if0.wdata[1] = 32'hBBBBBBBB;
    tick();
    if0.req = 2'b00;
    op0(0, 1'b0, 32'h44, 4'h0, 32'h0);
    chk("coll_bytes", if0.rdata[0], 32'hBBBBAAAA);

    // same-cycle write (port 0) and read (port 1): read sees old data
    if0.req = 2'b11; if0.we = 2'b01;
    if0.addr[0] = 32'h40; if0.addr[1] = 32'h40;
    if0.be[0] = 4'hF; if0.wdata[0] = 32'h55;
    tick();
    if0.req = 2'b00;
    chk("rdwr_old", if0.rdata[1], 32'h1);
    op0(1, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("rdwr_new", if0.rdata[1], 32'h55);

    // halt on port-0 access to HALT_ADDR, sticky
    chk("halt0_clear", 32'(halt0), 32'h0);
    op0(0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("halt0_set", 32'(halt0), 32'h1);
    tick();
    chk("halt0_sticky", 32'(halt0), 32'h1);

    // LATENCY=3: preload 1,2,3 then three back-to-back reads
    if1.req = 1'b1; if1.we = 1'b1; if1.be[0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      if1.addr[0]  = 32'(4 * i);
      if1.wdata[0] = 32'(i + 1);
      tick();
    end
    if1.req = 1'b0;
    repeat (4) tick();
    chk("halt1_set", 32'(halt1), 32'h1);
    if1.req = 1'b1; if1.we = 1'b0; if1.addr[0] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 2) if1.addr[0] = 32'(4 * (k + 1));
      else       if1.req = 1'b0;
      exp_v = (k >= 2) && (k <= 4);
      exp_d = 32'(k - 1);
      chk($sformatf("lat3_rvalid_k%0d", k), 32'(if1.rvalid[0]), 32'(exp_v));
      if (exp_v) chk($sformatf("lat3_rdata_k%0d", k), if1.rdata[0], exp_d);
    end

    // LFSR stalls: hold requests 1000 cycles
    low0 = 0; low1 = 0; acc0 = 0; acc1 = 0; rsp0 = 0; rsp1 = 0;
    if2.req = 2'b11; if2.we = 2'b00;
    if2.addr[0] = 32'h10; if2.addr[1] = 32'h20;
    for (int i = 0; i < 1000; i++) begin
      rsp0 += int'(if2.rvalid[0]);
      rsp1 += int'(if2.rvalid[1]);
      if (if2.gnt[0]) acc0++; else low0++;
      if (if2.gnt[1]) acc1++; else low1++;
      tick();
    end
    if2.req = 2'b00;
    repeat (4) begin
      rsp0 += int'(if2.rvalid[0]);
      rsp1 += int'(if2.rvalid[1]);
      tick();
    end
    chk("stall0_in_200_300", 32'((low0 >= 200) && (low0 <= 300)), 32'h1);
    chk("stall1_in_200_300", 32'((low1 >= 200) && (low1 <= 300)), 32'h1);
    chk("acc_eq_rsp0", 32'(rsp0), 32'(acc0));
    chk("acc_eq_rsp1", 32'(rsp1), 32'(acc1));

    // reset mid-burst discards in-flight responses
    if2.req = 2'b11;
    repeat (6) tick();
    rst2 = 1'b1;
    cnt  = 0;
    repeat (2) begin
      tick();
      cnt += int'(if2.rvalid[0]) + int'(if2.rvalid[1]);
    end
    rst2 = 1'b0;
    if2.req = 2'b00;
    repeat (4) begin
      tick();
      cnt += int'(if2.rvalid[0]) + int'(if2.rvalid[1]);
    end
    chk("no_rvalid_after_rst", 32'(cnt), 32'h0);

    // halt on the stalled instance
    chk("halt2_clear", 32'(halt2), 32'h0);
    if2.addr[0] = 32'h0; if2.req[0] = 1'b1;
    granted = 1'b0;
    for (int i = 0; i < 50 && !granted; i++) begin
      granted = if2.gnt[0];
      tick();
    end
    if2.req[0] = 1'b0;
    chk("halt2_granted", 32'(granted), 32'h1);
    chk("halt2_set",     32'(halt2),   32'h1);
    rst2 = 1'b1;
    tick();
    chk("halt2_rst", 32'(halt2), 32'h0);
    rst2 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
